stdp_stabilize_unit: RTL
========================

Name: stdp_stabilize_unit

Overview:
Sequential, parametrised weight-stabilised STDP update engine for one neuron's synapse bank. Latches a weight vector plus per-synapse potentiate/depress requests, then visits one synapse per cycle. Each update is gated by a stabilization BRV selected by the synapse's current weight. The BRVs come from programmable per-weight probability tables compared against an internal LFSR. Sits between the STDP case-generation logic and the synaptic weight store.

Parameters:
WRES, 3, weight resolution in bits; wmax = 2^WRES-1
NSYN, 8, synapses per bank (>=1)
PROB_W, 8, probability table entry width (<= LFSR_W)
LFSR_W, 16, LFSR width (fixed polynomial x^16+x^14+x^13+x^11+1; only 16 supported)
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  probability table write strobe
cfg_sel  in  1  0 = up (potentiation) table, 1 = down (depression) table
cfg_addr  in  WRES  weight level being programmed
cfg_data  in  PROB_W  probability value
start  in  1  one-cycle request to begin a bank update
weights_in  in  NSYN*WRES  packed weights; synapse i at [i*WRES +: WRES]
inc_req  in  NSYN  potentiation request per synapse
dec_req  in  NSYN  depression request per synapse
busy  out  1  high while processing
done  out  1  one-cycle pulse when the bank update completes
weights_out  out  NSYN*WRES  registered updated weights
inc_count  out  16  applied-increment count (optional feature)
dec_count  out  16  applied-decrement count (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; busy=0; done=0; weights_out=0; LFSR=SEED; synapse index=0; counters=0.
  - Both tables reset to all-ones in every entry.
- FSM: IDLE -> PROC -> DONE -> IDLE.
- IDLE:
  - start=1 latches weights_in into the weight registers, and inc_req/dec_req into request registers.
  - Index cleared to 0; next state PROC; busy=1 from the next cycle.
- PROC: one synapse per cycle, index 0..NSYN-1.
  - Inputs: w = weight[idx]; ru = LFSR[PROB_W-1:0]; rd = LFSR[LFSR_W-1 -: PROB_W].
  - up_brv = (ru < up_tab[w]) AND (w != wmax).
  - dn_brv = (rd < dn_tab[w]) AND (w != 0).
  - inc only and up_brv: w <= w+1.
  - dec only and dn_brv: w <= w-1.
  - inc AND dec together, or neither: no change.
  - No wrap-around ever: saturation is enforced by the w=wmax / w=0 gating.
  - LFSR advances once every PROC cycle, and only in PROC.
  - After idx = NSYN-1: go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle; next state IDLE.
  - weights_out already holds final values.
- Latency:
  - start sampled at edge T; done high in cycle T+NSYN+1.
  - busy high for cycles T+1 .. T+NSYN.
- start while busy or in DONE: ignored, with no effect on the current update.
- cfg_we:
  - Written synchronously in IDLE only, including the same cycle as start; the new entry is visible to the next update.
  - Ignored in PROC and DONE.
- Table entry 0 means never, for that table at that weight level.
- Entry 2^PROB_W-1 means probability (2^PROB_W-1)/2^PROB_W.
- weights_out changes only during PROC (per-synapse writes) and on start latch; it holds otherwise.
- Reset mid-PROC: immediate return to reset state; the partial update is discarded and done is not issued.

Optional Feature:
STAB_STATS_EN
- Defined:
  - inc_count and dec_count are 16-bit saturating counters (stick at 16'hFFFF), reset to 0.
  - They increment in each PROC cycle where an increment or decrement is actually applied.
  - They are cumulative across bank updates.
- Not defined: inc_count and dec_count are tied to 0, and no counter flops are inferred.

Test Plan:
- Reset: hold rst_n=0 -> busy=0, done=0, weights_out=0. Release, start with NSYN=8, all weights 3, no requests -> done at start+9 cycles, weights unchanged.
- Certain-never: program up_tab all 0; all weights 2, inc_req=8'hFF -> weights stay 2. Program up_tab all 8'hFF; repeat over 64 updates -> every weight reaches and saturates at 7, never wraps to 0.
- Floor: dn_tab all 8'hFF; weights all 0, dec_req=8'hFF -> weights remain 0, and dec_count unchanged (STAB_STATS_EN).
- Conflict: inc_req=dec_req=8'h0F, both tables 8'hFF, weights 4 -> synapses 0-3 stay 4; synapses 4-7 stay 4 (no request).
- Probability: up_tab[3]=8'h80, 1000 single-synapse updates from w=3 with inc_req=1 (reload w=3 each time) -> increment rate within 0.5±0.05; matches reference model stepping the same LFSR from SEED.
- Protocol: start pulse during busy, cfg_we during PROC, and rst_n low at PROC cycle 4 -> ignored, ignored, and immediate reset values with no done pulse.

Source files
------------

// File: rtl/stdp_stabilize_unit.sv
// ----------------------------------------------------------------------------
// stdp_stabilize_unit
//
// Weight-stabilised STDP update engine for one neuron's synapse bank.
// A start pulse latches the weight vector and the per-synapse potentiate and
// depress requests. The engine then visits one synapse per cycle. Each
// increment or decrement is gated by a Bernoulli draw. The draw compares a
// slice of a free-running (PROC-only) 16-bit LFSR against a programmable
// per-weight-level probability table.
//
// Optional feature: define STAB_STATS_EN to get saturating 16-bit counters
// of applied increments/decrements. When it is undefined, both count outputs
// are tied to zero.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   cfg_we_i       probability table write strobe (honoured in IDLE only)
//   cfg_sel_i      0 = up (potentiation) table, 1 = down (depression) table
//   cfg_addr_i     weight level being programmed
//   cfg_data_i     probability value
//   start_i        one-cycle request to begin a bank update
//   weights_in_i   packed weights, synapse i at [i*WRES +: WRES]
//   inc_req_i      potentiation request per synapse
//   dec_req_i      depression request per synapse
//   busy_o         high while synapses are being processed
//   done_o         one-cycle pulse when the bank update completes
//   weights_out_o  registered updated weights
//   inc_count_o    applied-increment count (STAB_STATS_EN)
//   dec_count_o    applied-decrement count (STAB_STATS_EN)
// ----------------------------------------------------------------------------
module stdp_stabilize_unit #(
   parameter int unsigned      WRES   = 3,
   parameter int unsigned      NSYN   = 8,
   parameter int unsigned      PROB_W = 8,
   parameter int unsigned      LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_we_i,
   input  logic                 cfg_sel_i,
   input  logic [WRES-1:0]      cfg_addr_i,
   input  logic [PROB_W-1:0]    cfg_data_i,
   input  logic                 start_i,
   input  logic [NSYN*WRES-1:0] weights_in_i,
   input  logic [NSYN-1:0]      inc_req_i,
   input  logic [NSYN-1:0]      dec_req_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [NSYN*WRES-1:0] weights_out_o,
   output logic [15:0]          inc_count_o,
   output logic [15:0]          dec_count_o
);

   localparam int unsigned     NLvl    = 1 << WRES;
   localparam int unsigned     IdxW    = (NSYN > 1) ? $clog2(NSYN) : 1;
   localparam logic [WRES-1:0] WMax    = {WRES{1'b1}};
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NSYN - 1);

   typedef enum logic [1:0] {
      StIdle,
      StProc,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [NSYN*WRES-1:0]  weights_q, weights_d;
   logic [NSYN-1:0]       inc_q, inc_d;
   logic [NSYN-1:0]       dec_q, dec_d;
   logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
   logic [PROB_W-1:0]     up_tab_q [NLvl];
   logic [PROB_W-1:0]     up_tab_d [NLvl];
   logic [PROB_W-1:0]     dn_tab_q [NLvl];
   logic [PROB_W-1:0]     dn_tab_d [NLvl];

   logic [WRES-1:0]       cur_w;
   logic [PROB_W-1:0]     ru, rd;
   logic                  up_brv, dn_brv;
   logic                  apply_inc, apply_dec;
   logic                  lfsr_fb;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      weights_d = weights_q;
      inc_d     = inc_q;
      dec_d     = dec_q;
      lfsr_d    = lfsr_q;
      up_tab_d  = up_tab_q;
      dn_tab_d  = dn_tab_q;
      apply_inc = 1'b0;
      apply_dec = 1'b0;

      cur_w  = weights_q[idx_q*WRES +: WRES];
      ru     = lfsr_q[PROB_W-1:0];
      rd     = lfsr_q[LFSR_W-1 -: PROB_W];
      // Level gating doubles as saturation: no wrap at either end.
      up_brv = (ru < up_tab_q[cur_w]) && (cur_w != WMax);
      dn_brv = (rd < dn_tab_q[cur_w]) && (cur_w != '0);

      unique case (state_q)
         StIdle: begin
            if (cfg_we_i) begin
               if (cfg_sel_i) begin
                  dn_tab_d[cfg_addr_i] = cfg_data_i;
               end else begin
                  up_tab_d[cfg_addr_i] = cfg_data_i;
               end
            end
            if (start_i) begin
               weights_d = weights_in_i;
               inc_d     = inc_req_i;
               dec_d     = dec_req_i;
               idx_d     = '0;
               state_d   = StProc;
            end
         end
         StProc: begin
            // Conflicting requests cancel out.
            apply_inc = inc_q[idx_q] && !dec_q[idx_q] && up_brv;
            apply_dec = dec_q[idx_q] && !inc_q[idx_q] && dn_brv;
            if (apply_inc) begin
               weights_d[idx_q*WRES +: WRES] = cur_w + 1'b1;
            end else if (apply_dec) begin
               weights_d[idx_q*WRES +: WRES] = cur_w - 1'b1;
            end
            lfsr_d = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
            if (idx_q == IdxLast) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         weights_q <= '0;
         inc_q     <= '0;
         dec_q     <= '0;
         lfsr_q    <= SEED;
         for (int i = 0; i < int'(NLvl); i++) begin
            up_tab_q[i] <= '1;
            dn_tab_q[i] <= '1;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         weights_q <= weights_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         lfsr_q    <= lfsr_d;
         up_tab_q  <= up_tab_d;
         dn_tab_q  <= dn_tab_d;
      end
   end

   assign busy_o        = (state_q == StProc);
   assign done_o        = (state_q == StDone);
   assign weights_out_o = weights_q;

`ifdef STAB_STATS_EN
   logic [15:0] inc_cnt_q, inc_cnt_d;
   logic [15:0] dec_cnt_q, dec_cnt_d;

   // Cumulative across bank updates; sticks at all-ones.
   always_comb begin
      inc_cnt_d = inc_cnt_q;
      dec_cnt_d = dec_cnt_q;
      if (apply_inc && (inc_cnt_q != 16'hFFFF)) begin
         inc_cnt_d = inc_cnt_q + 16'd1;
      end
      if (apply_dec && (dec_cnt_q != 16'hFFFF)) begin
         dec_cnt_d = dec_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inc_cnt_q <= '0;
         dec_cnt_q <= '0;
      end else begin
         inc_cnt_q <= inc_cnt_d;
         dec_cnt_q <= dec_cnt_d;
      end
   end

   assign inc_count_o = inc_cnt_q;
   assign dec_count_o = dec_cnt_q;
`else
   assign inc_count_o = '0;
   assign dec_count_o = '0;
`endif

endmodule
